// File: rtl/uart_prog_loader_pkg.sv
// Shared types and constants for the UART program loader.
package uart_prog_loader_pkg;

    localparam int unsigned DATA_WID  = 32;
    localparam int unsigned UART_BITS = 8;
    localparam int unsigned LANE_WID  = 2;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_state_t;

    typedef struct packed {
        logic [DATA_WID-1:0] data;
        logic [DATA_WID-1:0] addr;
    } uart_wr_t;

    // Byte address of word number idx, wrapping at 32 bits.
    function automatic logic [DATA_WID-1:0] word_addr(input logic [DATA_WID-1:0] base,
                                                      input logic [DATA_WID-1:0] idx);
        return base + (idx << 2);
    endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: rx synchronizer, baud counter and bit FSM.
// With UART_LOADER_TIMEOUT_EN an idle indication is exported for the loader.
module uart_rx_byte
    import uart_prog_loader_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    input  logic                 hold,
    output logic [UART_BITS-1:0] rx_byte,
    output logic                 byte_valid,
    output logic                 stop_err
`ifdef UART_LOADER_TIMEOUT_EN
    ,
    output logic                 idle_c
`endif
);

    localparam int unsigned CNT_WID = $clog2(CLKS_PER_BIT);
    localparam int unsigned IDX_WID = $clog2(UART_BITS);
    localparam logic [CNT_WID-1:0] HALF_M1 = CNT_WID'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_WID-1:0] FULL_M1 = CNT_WID'(CLKS_PER_BIT - 1);
    localparam logic [IDX_WID-1:0] LAST_IDX = IDX_WID'(UART_BITS - 1);

    uart_state_t          state_q, state_d;
    logic                 rx_meta_q, rx_sync_q;
    logic [CNT_WID-1:0]   cnt_q, cnt_d;
    logic [IDX_WID-1:0]   idx_q, idx_d;
    logic [UART_BITS-1:0] shift_q, shift_d;
    logic                 err_wait_q, err_wait_d;
    logic                 byte_valid_q, byte_valid_d;
    logic                 stop_err_q, stop_err_d;
    logic                 half_tick_c, full_tick_c;

    assign half_tick_c = (cnt_q == HALF_M1);
    assign full_tick_c = (cnt_q == FULL_M1);

    // State and datapath registers; the synchronizer idles high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            rx_meta_q    <= 1'b1;
            rx_sync_q    <= 1'b1;
            cnt_q        <= '0;
            idx_q        <= '0;
            shift_q      <= '0;
            err_wait_q   <= 1'b0;
            byte_valid_q <= 1'b0;
            stop_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            rx_meta_q    <= rx;
            rx_sync_q    <= rx_meta_q;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            shift_q      <= shift_d;
            err_wait_q   <= err_wait_d;
            byte_valid_q <= byte_valid_d;
            stop_err_q   <= stop_err_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (!rx_sync_q) state_d = START;
            START: if (half_tick_c) state_d = rx_sync_q ? IDLE : DATA;
            DATA:  if (full_tick_c && (idx_q == LAST_IDX)) state_d = STOP;
            STOP: begin
                if (err_wait_q) begin
                    if (rx_sync_q) state_d = IDLE;
                end else if (full_tick_c && rx_sync_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (hold) state_d = IDLE;
    end

    // Counter, shifter and byte/error strobes.
    always_comb begin
        cnt_d        = cnt_q + 1'b1;
        idx_d        = idx_q;
        shift_d      = shift_q;
        err_wait_d   = err_wait_q;
        byte_valid_d = 1'b0;
        stop_err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d      = '0;
                err_wait_d = 1'b0;
            end
            START: begin
                if (half_tick_c) begin
                    cnt_d = '0;
                    idx_d = '0;
                end
            end
            DATA: begin
                if (full_tick_c) begin
                    cnt_d   = '0;
                    shift_d = {rx_sync_q, shift_q[UART_BITS-1:1]};
                    idx_d   = idx_q + 1'b1;
                end
            end
            STOP: begin
                if (err_wait_q) begin
                    cnt_d = '0;
                end else if (full_tick_c) begin
                    cnt_d = '0;
                    if (rx_sync_q) begin
                        byte_valid_d = 1'b1;
                    end else begin
                        stop_err_d = 1'b1;
                        err_wait_d = 1'b1;
                    end
                end
            end
            default: ;
        endcase
        if (hold) begin
            cnt_d        = '0;
            err_wait_d   = 1'b0;
            byte_valid_d = 1'b0;
            stop_err_d   = 1'b0;
        end
    end

    assign rx_byte    = shift_q;
    assign byte_valid = byte_valid_q;
    assign stop_err   = stop_err_q;

`ifdef UART_LOADER_TIMEOUT_EN
    assign idle_c = (state_q == IDLE);
`endif

endmodule

// File: rtl/uart_prog_loader.sv
// UART boot loader: assembles little-endian words and drives the program-load port.
// Optional UART_LOADER_TIMEOUT_EN completes a short image after TIMEOUT_CLKS idle cycles.
module uart_prog_loader
    import uart_prog_loader_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned WORD_COUNT   = 16384,
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0000
`ifdef UART_LOADER_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CLKS = 5_000_000
`endif
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               rx,
    output logic [DATA_WID-1:0]                uart_data,
    output logic [DATA_WID-1:0]                uart_addr,
    output logic                               uart_we,
    output logic                               uart_done,
    output logic                               frame_err,
    output logic [$clog2(WORD_COUNT+1)-1:0]    words_loaded
);

    localparam int unsigned WC_WID = $clog2(WORD_COUNT + 1);

    logic [UART_BITS-1:0] rx_byte;
    logic                 byte_valid;
    logic                 stop_err;
    logic                 timeout_c;

    uart_wr_t             wr_q, wr_d;
    logic [DATA_WID-1:0]  word_q, word_d;
    logic [LANE_WID-1:0]  lane_q, lane_d;
    logic                 we_q, we_d;
    logic                 done_q, done_d;
    logic                 ferr_q, ferr_d;
    logic [WC_WID-1:0]    words_q, words_d;

`ifdef UART_LOADER_TIMEOUT_EN
    localparam int unsigned TO_WID = $clog2(TIMEOUT_CLKS + 1);

    logic              rx_idle_c;
    logic [TO_WID-1:0] idle_cnt_q, idle_cnt_d;

    uart_rx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_rx (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (rx),
        .hold       (done_q),
        .rx_byte    (rx_byte),
        .byte_valid (byte_valid),
        .stop_err   (stop_err),
        .idle_c     (rx_idle_c)
    );

    // Idle timer only runs between whole words; any activity restarts it.
    always_comb begin
        idle_cnt_d = '0;
        if (rx_idle_c && (words_q != '0) && (lane_q == '0) && !done_q) begin
            idle_cnt_d = idle_cnt_q + 1'b1;
        end
    end

    assign timeout_c = (idle_cnt_d == TO_WID'(TIMEOUT_CLKS));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) idle_cnt_q <= '0;
        else        idle_cnt_q <= idle_cnt_d;
    end
`else
    uart_rx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_rx (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (rx),
        .hold       (done_q),
        .rx_byte    (rx_byte),
        .byte_valid (byte_valid),
        .stop_err   (stop_err)
    );

    assign timeout_c = 1'b0;
`endif

    // Lane assembly, write strobe, address generation and completion.
    always_comb begin
        wr_d    = wr_q;
        word_d  = word_q;
        lane_d  = lane_q;
        we_d    = 1'b0;
        done_d  = done_q;
        ferr_d  = ferr_q | stop_err;
        words_d = words_q;
        if (byte_valid && !done_q) begin
            word_d[{lane_q, 3'b000} +: UART_BITS] = rx_byte;
            lane_d = lane_q + 1'b1;
            if (lane_q == LANE_WID'(3)) begin
                wr_d.data = {rx_byte, word_q[23:0]};
                wr_d.addr = word_addr(BASE_ADDR, DATA_WID'(words_q));
                we_d      = 1'b1;
                words_d   = words_q + 1'b1;
                if (words_d == WC_WID'(WORD_COUNT)) done_d = 1'b1;
            end
        end
        if (timeout_c) done_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q    <= '{data: '0, addr: BASE_ADDR};
            word_q  <= '0;
            lane_q  <= '0;
            we_q    <= 1'b0;
            done_q  <= 1'b0;
            ferr_q  <= 1'b0;
            words_q <= '0;
        end else begin
            wr_q    <= wr_d;
            word_q  <= word_d;
            lane_q  <= lane_d;
            we_q    <= we_d;
            done_q  <= done_d;
            ferr_q  <= ferr_d;
            words_q <= words_d;
        end
    end

    assign uart_data    = wr_q.data;
    assign uart_addr    = wr_q.addr;
    assign uart_we      = we_q;
    assign uart_done    = done_q;
    assign frame_err    = ferr_q;
    assign words_loaded = words_q;

endmodule

// File: tb/tb_uart_prog_loader.sv
// Scoreboard bench for uart_prog_loader with a byte-queue reference model.
module tb_uart_prog_loader;

    localparam int unsigned CPB  = 4;
    localparam int unsigned WC   = 2;
    localparam logic [31:0] BASE = 32'h0000_0100;

    logic clk = 1'b0;
    logic rst_n;
    logic rx;
    logic [31:0] uart_data;
    logic [31:0] uart_addr;
    logic uart_we;
    logic uart_done;
    logic frame_err;
    logic [$clog2(WC+1)-1:0] words_loaded;

    always #5 clk = ~clk;

    uart_prog_loader #(
        .CLKS_PER_BIT (CPB),
        .WORD_COUNT   (WC),
        .BASE_ADDR    (BASE)
`ifdef UART_LOADER_TIMEOUT_EN
        ,
        .TIMEOUT_CLKS (50)
`endif
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx           (rx),
        .uart_data    (uart_data),
        .uart_addr    (uart_addr),
        .uart_we      (uart_we),
        .uart_done    (uart_done),
        .frame_err    (frame_err),
        .words_loaded (words_loaded)
    );

    typedef struct {
        logic [31:0] data;
        logic [31:0] addr;
        int unsigned words;
        logic        done;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   n_cmp = 0;
    int   n_err = 0;

    // Reference model: bytes collected in a queue, four valid bytes make a word.
    logic [7:0]  m_buf[$];
    int unsigned m_words;
    bit          m_done;
    bit          m_ferr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        m_buf.delete();
        m_words = 0;
        m_done  = 1'b0;
        m_ferr  = 1'b0;
        exp_q.delete();
    endtask

    task automatic model_byte(input logic [7:0] b, input bit stop_ok);
        exp_t x;
        if (m_done) return;
        if (!stop_ok) begin
            m_ferr = 1'b1;
            return;
        end
        m_buf.push_back(b);
        if (m_buf.size() == 4) begin
            x.data  = {m_buf[3], m_buf[2], m_buf[1], m_buf[0]};
            x.addr  = BASE + 32'(m_words) * 32'd4;
            x.words = m_words + 1;
            x.done  = (m_words + 1 == WC);
            exp_q.push_back(x);
            m_words++;
            if (m_words == WC) m_done = 1'b1;
            m_buf.delete();
        end
    endtask

    task automatic rx_bit(input logic v);
        @(negedge clk) rx = v;
        repeat (CPB - 1) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop_ok);
        model_byte(b, stop_ok);
        rx_bit(1'b0);
        for (int i = 0; i < 8; i++) rx_bit(b[i]);
        rx_bit(stop_ok);
        if (!stop_ok) rx_bit(1'b1);
        rx_bit(1'b1);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_data"},  uart_data, 32'h0);
        check({tag, "_addr"},  uart_addr, BASE);
        check({tag, "_we"},    32'(uart_we), 32'h0);
        check({tag, "_done"},  32'(uart_done), 32'h0);
        check({tag, "_ferr"},  32'(frame_err), 32'h0);
        check({tag, "_words"}, 32'(words_loaded), 32'h0);
    endtask

    task automatic apply_reset();
        @(negedge clk) rst_n = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic drain();
        int guard = 0;
        while (exp_q.size() != 0 && guard < 400) begin
            @(negedge clk);
            guard++;
        end
        check("drain_pending", 32'(exp_q.size()), 32'h0);
    endtask

    // Monitor: pops expectations on every write strobe and checks stability otherwise.
    logic [31:0] prev_data, prev_addr;
    bit          prev_valid = 1'b0;
    bit          prev_we    = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_valid = 1'b0;
            prev_we    = 1'b0;
        end else begin
            if (uart_we) begin
                check("we_one_cycle", 32'(prev_we), 32'h0);
                if (exp_q.size() == 0) begin
                    check("unexpected_we", 32'h1, 32'h0);
                end else begin
                    e = exp_q.pop_front();
                    check("we_data",  uart_data, e.data);
                    check("we_addr",  uart_addr, e.addr);
                    check("we_words", 32'(words_loaded), 32'(e.words));
                    check("we_done",  32'(uart_done), 32'(e.done));
                end
            end else if (prev_valid) begin
                check("data_stable", uart_data, prev_data);
                check("addr_stable", uart_addr, prev_addr);
            end
            prev_data  = uart_data;
            prev_addr  = uart_addr;
            prev_valid = 1'b1;
            prev_we    = uart_we;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned nb;
        logic [7:0]  b;
        bit          ok;

        rx    = 1'b1;
        rst_n = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_outputs("reset");

        // One-clock low pulse must be rejected in START.
        @(negedge clk) rx = 1'b0;
        @(negedge clk) rx = 1'b1;
        repeat (10) @(negedge clk);
        check("glitch_ferr",  32'(frame_err), 32'h0);
        check("glitch_words", 32'(words_loaded), 32'h0);

        // Framing error leaves the lane untouched.
        send_byte(8'hAA, 1'b0);
        repeat (2) @(negedge clk);
        check("ferr_set", 32'(frame_err), 32'h1);
        send_word(32'h1234_5678);
        repeat (4) @(negedge clk);
        check("w0_words", 32'(words_loaded), 32'h1);
        check("w0_done",  32'(uart_done), 32'h0);
        drain();

        // Reset in the middle of a word.
        send_byte(8'h78, 1'b1);
        send_byte(8'h56, 1'b1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        model_reset();
        #1 check_reset_outputs("midreset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        send_word(32'h1234_5678);
        send_word(32'hDEAD_BEEF);
        repeat (4) @(negedge clk);
        check("full_done",  32'(uart_done), 32'h1);
        check("full_words", 32'(words_loaded), 32'(WC));
        drain();

        // Traffic after completion is ignored.
        for (int i = 0; i < 8; i++) send_byte(8'($urandom), 1'b1);
        repeat (4) @(negedge clk);
        check("post_data",  uart_data, 32'hDEAD_BEEF);
        check("post_addr",  uart_addr, BASE + 32'd4);
        check("post_words", 32'(words_loaded), 32'(WC));
        check("post_done",  32'(uart_done), 32'h1);

        // Short image: completion only when the idle timeout is built in.
        apply_reset();
        send_word(32'($urandom));
        repeat (60) @(negedge clk);
        check("short_words", 32'(words_loaded), 32'h1);
`ifdef UART_LOADER_TIMEOUT_EN
        check("short_done", 32'(uart_done), 32'h1);
`else
        check("short_done", 32'(uart_done), 32'h0);
`endif
        drain();

        // Randomized byte streams with occasional framing errors.
        for (int it = 0; it < 6; it++) begin
            apply_reset();
            nb = $urandom_range(4, 11);
            for (int k = 0; k < int'(nb); k++) begin
                b  = 8'($urandom);
                ok = ($urandom_range(0, 5) != 0);
                send_byte(b, ok);
            end
            repeat (4) @(negedge clk);
            check("rand_words", 32'(words_loaded), 32'(m_words));
            check("rand_done",  32'(uart_done), 32'(m_done));
            check("rand_ferr",  32'(frame_err), 32'(m_ferr));
            drain();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_prog_loader.md
Name: uart_prog_loader

Overview:
Serial boot loader that drives the core's program-load interface (uart_data, uart_addr, uart_done).
- Receives 8N1 UART bytes on rx and assembles them little-endian into 32-bit words.
- Presents each word with its byte address to the memory write port.
- Raises uart_done once the image is complete, which releases the core from reset.
- Sits at the board top, between the RX pin and the core.

Parameters:
CLKS_PER_BIT, 434, clock cycles per UART bit (50 MHz / 115200); must be >= 4.
WORD_COUNT, 16384, number of 32-bit words in a complete image.
BASE_ADDR, 32'h0000_0000, byte address of the first word.
TIMEOUT_CLKS, 5_000_000, idle cycles before early completion (used only with the optional feature).

Ports:
clk  input  1  system clock, single clock domain.
rst_n  input  1  asynchronous active-low reset.
rx  input  1  UART serial input, idle high, asynchronous to clk.
uart_data  output  32  last assembled word, held stable until the next word.
uart_addr  output  32  byte address of uart_data.
uart_we  output  1  one-cycle strobe when a new uart_data/uart_addr pair is presented.
uart_done  output  1  image load complete; sticky until reset.
frame_err  output  1  sticky flag: a stop bit was sampled low at least once.
words_loaded  output  $clog2(WORD_COUNT+1)  count of words written so far.

Behaviour:
- Reset is asynchronous, active low. All outputs and internal state clear immediately on assertion:
  - uart_data=0, uart_addr=BASE_ADDR, uart_we=0, uart_done=0, frame_err=0, words_loaded=0.
  - Byte lane=0; FSM goes to IDLE.
  - Reset mid-byte or mid-word discards the partial data.
- rx passes through a 2-flop synchronizer, reset value 1. All sampling uses the synchronized signal.
- Bit FSM:
  - IDLE: on a falling edge (rx_sync=0), clear the baud counter and go to START.
  - START: at CLKS_PER_BIT/2 cycles, sample rx_sync. If 0, go to DATA with bit index 0. If 1 (glitch), return to IDLE.
  - DATA: sample every CLKS_PER_BIT cycles, LSB first, into a shift register. After bit 7, go to STOP.
  - STOP: sample after CLKS_PER_BIT cycles.
    - If 1: byte valid for one cycle.
    - If 0: set frame_err, discard the byte, leave the lane unchanged, and wait in STOP until rx_sync=1 before returning to IDLE.
  - After a valid stop, go directly to IDLE. A start edge arriving in the second half of the stop bit is still caught.
- Word assembly:
  - A valid byte writes into lane[1:0]: lane 0 goes to bits[7:0], lane 3 to bits[31:24]. The lane then increments.
  - On the valid byte for lane 3, in the next cycle:
    - uart_data <= assembled word.
    - uart_addr <= BASE_ADDR + 4*words_loaded (32-bit wrap).
    - uart_we=1 for exactly one cycle.
    - words_loaded increments and lane returns to 0.
- Completion:
  - On the cycle words_loaded reaches WORD_COUNT, uart_done goes to 1 together with the final uart_we pulse.
  - Once done, the FSM is forced to IDLE and further rx activity is ignored: no uart_we, no change to uart_data, uart_addr or words_loaded.
- uart_data and uart_addr are registered, glitch-free, and stable between strobes. The consumer writes continuously while uart_done=0, so a stable pair is mandatory.
- Latency: uart_we asserts 1 clk after the stop-bit sample of the fourth byte, plus 2 clk of synchronizer delay from the rx pin.

Optional Feature:
UART_LOADER_TIMEOUT_EN
- Defined: an idle counter runs while in IDLE with words_loaded>0 and lane==0. It resets on any start edge. On reaching TIMEOUT_CLKS, uart_done=1 with no uart_we. This supports images shorter than WORD_COUNT. A partial word (lane!=0) blocks the timeout.
- Undefined: no counter is present; uart_done is set only by the word count.

Decomposition:
- Shared package entries:
  - uart_state_t enum {IDLE, START, DATA, STOP}.
  - Constant UART_BITS=8.
  - Existing DATA_WID for the 32-bit width.
- Sub-module uart_rx_byte: synchronizer, baud counter, bit FSM. Outputs byte[7:0], byte_valid, stop_err.
- uart_prog_loader contains the lane/word assembly, address generation, done logic and timeout.

Test Plan:
- All tests use CLKS_PER_BIT=4, WORD_COUNT=2, BASE_ADDR=0x100.
- Send bytes 78 56 34 12 -> one uart_we pulse; uart_data=0x12345678, uart_addr=0x100, words_loaded=1, uart_done=0.
- Then send EF BE AD DE -> uart_data=0xDEADBEEF, uart_addr=0x104, uart_done=1 in the same cycle as uart_we. Then send 8 further bytes -> no uart_we, outputs unchanged.
- rx low pulse of 1 clk on idle line -> START rejects it as a glitch; no byte, frame_err=0.
- Send byte 0xAA with stop bit low -> frame_err=1, lane unchanged. Then send 78 56 34 12 -> word 0x12345678 is still assembled correctly.
- Assert rst_n=0 after 2 bytes of a word -> all outputs return to reset values immediately. Then send 4 fresh bytes -> they form word 0 at 0x100.
- With UART_LOADER_TIMEOUT_EN and TIMEOUT_CLKS=50: send 1 word, then idle 50 clk -> uart_done=1, words_loaded=1.
